// File: rtl/pbs_pkg.sv
// pbs_pkg: shared move-table defaults, resolver state encoding and LFSR taps.
package pbs_pkg;
    typedef enum logic [1:0] {IDLE, ROLL, RESP} state_t;

    // x^8+x^6+x^5+x^4+1 mapped onto a left-shifting register (bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int DEF_DMG [4] = '{3, 7, 10, 15};
    localparam int DEF_ACC [4] = '{15, 12, 10, 5};

    function automatic int def_dmg(input int i);
        return i < 4 ? DEF_DMG[i] : 0;
    endfunction

    function automatic int def_acc(input int i);
        return i < 4 ? DEF_ACC[i] : -1;
    endfunction
endpackage

// File: rtl/pbs_lfsr8.sv
// pbs_lfsr8: free-running 8-bit Fibonacci LFSR, reloads SEED on reset.
module pbs_lfsr8
    import pbs_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= SEED;
        else q <= {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/move_resolver.sv
// move_resolver: table-driven move resolution with PP budget and LFSR accuracy roll.
// Define MOVE_RESOLVER_CRIT_EN to enable critical hits with saturating double damage.
module move_resolver
    import pbs_pkg::*;
#(
    parameter int         NUM_MOVES = 4,
    parameter int         DMG_W     = 4,
    parameter int         ACC_W     = 4,
    parameter int         PP_INIT   = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    localparam int        IW        = $clog2(NUM_MOVES),
    localparam int        PW        = $clog2(PP_INIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IW-1:0]    req_move,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [DMG_W-1:0] rsp_dmg,
    output logic             rsp_no_pp,
    output logic             rsp_crit,
    output logic [PW-1:0]    rsp_pp_left,
    input  logic             pp_refill,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [DMG_W-1:0] cfg_dmg,
    input  logic [ACC_W-1:0] cfg_acc
);
    state_t state, state_nx;
    logic [7:0] lfsr;
    logic [DMG_W-1:0] dmg_tab [NUM_MOVES];
    logic [ACC_W-1:0] acc_tab [NUM_MOVES];
    logic [PW-1:0] pp [NUM_MOVES];
    logic [IW-1:0] idx, sel;
    logic [DMG_W-1:0] l_dmg, dmg_nx;
    logic [ACC_W-1:0] l_acc;
    logic [PW-1:0] pp_cur;
    logic no_pp, hit, crit;

    pbs_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .q(lfsr));

    assign sel       = 32'(req_move) < NUM_MOVES ? req_move : '0;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;

    always_comb begin
        pp_cur   = pp[idx];
        no_pp    = pp_cur == '0;
        hit      = !no_pp && (&l_acc || lfsr[ACC_W-1:0] < l_acc);
        crit     = 1'b0;
        dmg_nx   = hit ? l_dmg : '0;
`ifdef MOVE_RESOLVER_CRIT_EN
        crit     = hit && lfsr[7:4] == 4'b0000;
        if (crit) dmg_nx = l_dmg[DMG_W-1] ? '1 : {l_dmg[DMG_W-2:0], 1'b0};
`endif
        state_nx = state == IDLE && req_valid ? ROLL :
                   state == ROLL              ? RESP :
                   state == RESP && rsp_ready ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            l_dmg       <= '0;
            l_acc       <= '0;
            rsp_hit     <= 1'b0;
            rsp_dmg     <= '0;
            rsp_no_pp   <= 1'b0;
            rsp_crit    <= 1'b0;
            rsp_pp_left <= '0;
            for (int i = 0; i < NUM_MOVES; i++) begin
                dmg_tab[i] <= DMG_W'(def_dmg(i));
                acc_tab[i] <= ACC_W'(def_acc(i));
                pp[i]      <= PW'(PP_INIT);
            end
        end else begin
            if (req_ready && req_valid) begin
                idx   <= sel;
                l_dmg <= dmg_tab[sel];
                l_acc <= acc_tab[sel];
            end
            if (cfg_we) begin
                dmg_tab[cfg_idx] <= cfg_dmg;
                acc_tab[cfg_idx] <= cfg_acc;
            end
            if (state == ROLL) begin
                rsp_hit     <= hit;
                rsp_dmg     <= dmg_nx;
                rsp_no_pp   <= no_pp;
                rsp_crit    <= crit;
                rsp_pp_left <= pp_refill ? PW'(PP_INIT) : no_pp ? '0 : pp_cur - PW'(1);
                if (!no_pp) pp[idx] <= pp_cur - PW'(1);
            end
            // refill is applied last so it overrides a same-cycle decrement
            if (pp_refill)
                for (int i = 0; i < NUM_MOVES; i++) pp[i] <= PW'(PP_INIT);
        end
    end
endmodule

// File: tb/tb_move_resolver.sv
// tb_move_resolver: directed checks of move_resolver with a reference table, PP and LFSR model.
module tb_move_resolver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_move = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_hit;
    logic [3:0] rsp_dmg;
    logic       rsp_no_pp;
    logic       rsp_crit;
    logic [3:0] rsp_pp_left;
    logic       pp_refill = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [3:0] cfg_dmg = '0;
    logic [3:0] cfg_acc = '0;

    int checks = 0;
    int passes = 0;

    logic [7:0]  m_lfsr;
    int          m_dmg [4];
    int          m_acc [4];
    int          m_pp  [4];
    logic [11:0] rsp_vec;

    assign rsp_vec = {rsp_valid, rsp_hit, rsp_no_pp, rsp_crit, rsp_dmg, rsp_pp_left};

    move_resolver dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_move(req_move), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_dmg(rsp_dmg), .rsp_no_pp(rsp_no_pp), .rsp_crit(rsp_crit),
        .rsp_pp_left(rsp_pp_left), .pp_refill(pp_refill), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_dmg(cfg_dmg), .cfg_acc(cfg_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 8'hA5;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    task automatic model_reset();
        m_dmg = '{3, 7, 10, 15};
        m_acc = '{15, 12, 10, 5};
        m_pp  = '{8, 8, 8, 8};
    endtask

    task automatic model_step(input int mv, input logic [7:0] rl, input logic refill,
                              output logic [11:0] e);
        logic h, c;
        int d;
        if (m_pp[mv] == 0) begin
            e = {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, refill ? 4'd8 : 4'd0};
        end else begin
            h = m_acc[mv] == 15 || int'(rl[3:0]) < m_acc[mv];
            d = h ? m_dmg[mv] : 0;
            c = 1'b0;
`ifdef MOVE_RESOLVER_CRIT_EN
            c = h && rl[7:4] == 4'd0;
            if (c) d = d * 2 > 15 ? 15 : d * 2;
`endif
            m_pp[mv] = m_pp[mv] - 1;
            e = {1'b1, h, 1'b0, c, 4'(d), refill ? 4'd8 : 4'(m_pp[mv])};
        end
        if (refill) m_pp = '{8, 8, 8, 8};
    endtask

    // Issues one request; returns at the falling edge of the first RESP cycle.
    task automatic req_resp(input int mv, input logic refill,
                            output logic [7:0] rl, output logic v_roll);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++;
            $display("FAIL req_ready_timeout got=%b want=1", req_ready);
        end
        req_valid = 1'b1;
        req_move  = 2'(mv);
        @(negedge clk);
        req_valid = 1'b0;
        pp_refill = refill;
        rl        = m_lfsr;
        v_roll    = rsp_valid;
        @(negedge clk);
        pp_refill = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, rsp_vec} !== 13'h1000)
            $display("FAIL reset_in got=%h want=%h", {req_ready, rsp_vec}, 13'h1000);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_vec} !== 13'h1000)
            $display("FAIL reset_out got=%h want=%h", {req_ready, rsp_vec}, 13'h1000);
        else passes++;
    endtask

    task automatic test_basic();
        logic [7:0] rl;
        logic vr;
        logic [11:0] e;
        req_resp(0, 1'b0, rl, vr);
        model_step(0, rl, 1'b0, e);
        checks++;
        if (vr !== 1'b0) $display("FAIL basic_roll_valid got=%b want=0", vr);
        else passes++;
        checks++;
        if (rsp_vec !== e) $display("FAIL basic_rsp got=%h want=%h", rsp_vec, e);
        else passes++;
        checks++;
        if ({rsp_valid, rsp_hit, rsp_pp_left} !== {2'b11, 4'd7})
            $display("FAIL basic_hit_pp got=%b%b/%0d want=11/7", rsp_valid, rsp_hit, rsp_pp_left);
        else passes++;
    endtask

    task automatic test_pp_exhaust();
        logic [7:0] rl;
        logic vr;
        logic [11:0] e;
        for (int k = 1; k <= 9; k++) begin
            req_resp(3, 1'b0, rl, vr);
            model_step(3, rl, 1'b0, e);
            checks++;
            if (rsp_vec !== e) $display("FAIL exhaust_%0d got=%h want=%h", k, rsp_vec, e);
            else passes++;
            checks++;
            if (rsp_pp_left !== 4'(k < 9 ? 8 - k : 0))
                $display("FAIL exhaust_pp_%0d got=%0d want=%0d", k, rsp_pp_left, k < 9 ? 8 - k : 0);
            else passes++;
        end
        checks++;
        if ({rsp_no_pp, rsp_hit, rsp_dmg} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL exhaust_nopp got=%b%b/%0d want=10/0", rsp_no_pp, rsp_hit, rsp_dmg);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rl;
        logic [11:0] e, held;
        int extra = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_move  = 2'd2;
        @(negedge clk);
        rl = m_lfsr;
        @(negedge clk);
        model_step(2, rl, 1'b0, e);
        held = rsp_vec;
        checks++;
        if (rsp_vec !== e) $display("FAIL bp_first got=%h want=%h", rsp_vec, e);
        else passes++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, rsp_vec} !== {1'b0, held})
                $display("FAIL bp_hold_%0d got=%h want=%h", k, {req_ready, rsp_vec}, {1'b0, held});
            else passes++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10)
            $display("FAIL bp_release got=%b want=10", {req_ready, rsp_valid});
        else passes++;
        @(negedge clk);
        req_valid = 1'b0;
        rl = m_lfsr;
        @(negedge clk);
        model_step(2, rl, 1'b0, e);
        checks++;
        if (rsp_vec !== e || rsp_pp_left !== 4'd6)
            $display("FAIL bp_second got=%h want=%h", rsp_vec, e);
        else passes++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL bp_duplicate got=%0d want=0", extra);
        else passes++;
    endtask

    task automatic test_cfg_write();
        logic [7:0] rl;
        logic vr;
        logic [11:0] e;
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_dmg = 4'd9; cfg_acc = 4'd15;
        @(negedge clk);
        cfg_we = 1'b0;
        m_dmg[1] = 9; m_acc[1] = 15;
        req_resp(1, 1'b0, rl, vr);
        model_step(1, rl, 1'b0, e);
        checks++;
        if ({rsp_hit, rsp_dmg} !== {1'b1, 4'd9} || rsp_vec !== e)
            $display("FAIL cfg_new got=%h want=%h", rsp_vec, e);
        else passes++;
        // write idx1 in the very cycle a move-1 request is accepted
        @(negedge clk);
        req_valid = 1'b1; req_move = 2'd1;
        cfg_we = 1'b1; cfg_dmg = 4'd5; cfg_acc = 4'd15;
        @(negedge clk);
        req_valid = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_hit, rsp_dmg} !== {2'b11, 4'd9})
            $display("FAIL cfg_race got=%b%b/%0d want=11/9", rsp_valid, rsp_hit, rsp_dmg);
        else passes++;
        m_pp[1] = m_pp[1] - 1;
        m_dmg[1] = 5;
        req_resp(1, 1'b0, rl, vr);
        model_step(1, rl, 1'b0, e);
        checks++;
        if (rsp_dmg !== 4'd5 || rsp_vec !== e)
            $display("FAIL cfg_after got=%h want=%h", rsp_vec, e);
        else passes++;
    endtask

    task automatic test_refill();
        logic [7:0] rl;
        logic vr;
        logic [11:0] e;
        for (int k = 0; k < 3; k++) begin
            req_resp(2, 1'b0, rl, vr);
            model_step(2, rl, 1'b0, e);
        end
        checks++;
        if (rsp_pp_left !== 4'd3) $display("FAIL refill_pre got=%0d want=3", rsp_pp_left);
        else passes++;
        req_resp(2, 1'b1, rl, vr);
        model_step(2, rl, 1'b1, e);
        checks++;
        if (rsp_pp_left !== 4'd8 || rsp_vec !== e)
            $display("FAIL refill_win got=%h want=%h", rsp_vec, e);
        else passes++;
        req_resp(2, 1'b0, rl, vr);
        model_step(2, rl, 1'b0, e);
        checks++;
        if (rsp_pp_left !== 4'd7 || rsp_vec !== e)
            $display("FAIL refill_next got=%h want=%h", rsp_vec, e);
        else passes++;
        req_resp(3, 1'b0, rl, vr);
        model_step(3, rl, 1'b0, e);
        checks++;
        if (rsp_vec !== e || rsp_no_pp !== 1'b0)
            $display("FAIL refill_move3 got=%h want=%h", rsp_vec, e);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] rl;
        logic vr;
        logic [11:0] e;
        @(negedge clk);
        req_valid = 1'b1; req_move = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_vec} !== 13'h1000)
            $display("FAIL midrst_out got=%h want=%h", {req_ready, rsp_vec}, 13'h1000);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10)
            $display("FAIL midrst_idle got=%b want=10", {req_ready, rsp_valid});
        else passes++;
        for (int k = 0; k < 4; k++) begin
            req_resp(3 - k, 1'b0, rl, vr);
            model_step(3 - k, rl, 1'b0, e);
            checks++;
            if (rsp_vec !== e || rsp_pp_left !== 4'd7)
                $display("FAIL midrst_move%0d got=%h want=%h", 3 - k, rsp_vec, e);
            else passes++;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_pp_exhaust();
        test_back_to_back();
        test_cfg_write();
        test_refill();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/move_resolver.md
Name: move_resolver

Overview:
- Parametrised, sequential successor to the combinational move-to-damage/accuracy lookup.
- Holds a programmable per-move table of damage and accuracy values.
- Tracks a power-point (PP) budget per move and rolls an internal LFSR for the accuracy check.
- Returns a hit/damage result over a valid/ready handshake; sits between player input decode and the HP update logic.

Parameters:
- NUM_MOVES, 4, number of selectable moves (≥2).
- DMG_W, 4, damage width.
- ACC_W, 4, accuracy width (≤8); all-ones means always hit.
- PP_INIT, 8, PP per move after reset or refill (≥1).
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  1  move request.
- req_ready  out  1  block idle; can accept a request.
- req_move  in  $clog2(NUM_MOVES)  selected move index.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_hit  out  1  move landed.
- rsp_dmg  out  DMG_W  damage dealt (0 on miss or no PP).
- rsp_no_pp  out  1  move had 0 PP; not executed.
- rsp_crit  out  1  critical hit (see Optional Feature).
- rsp_pp_left  out  $clog2(PP_INIT+1)  PP remaining for that move after the request.
- pp_refill  in  1  pulse; restores every move's PP to PP_INIT.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  $clog2(NUM_MOVES)  table entry to write.
- cfg_dmg  in  DMG_W  damage value to write.
- cfg_acc  in  ACC_W  accuracy value to write.

Behaviour:
- One clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - req_ready=1; rsp_valid, rsp_hit, rsp_dmg, rsp_no_pp, rsp_crit, rsp_pp_left all 0.
  - State IDLE; LFSR=LFSR_SEED; all PP counters=PP_INIT.
  - Table defaults (dmg/acc): idx0 3/15, idx1 7/12, idx2 10/10, idx3 15/5; idx≥4 0/all-ones. Values are truncated/extended to DMG_W/ACC_W.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle including while idle.
- State machine IDLE -> ROLL -> RESP -> IDLE:
  - IDLE: req_ready=1. On req_valid, latch the move index and its table dmg/acc, then go to ROLL.
  - ROLL (1 cycle): roll = lfsr[ACC_W-1:0].
    - If PP==0: no_pp=1, hit=0, dmg=0, PP unchanged.
    - Else: PP decrements by 1 whether the move hits or misses. hit = (acc==all-ones) || (roll < acc); dmg = hit ? latched dmg : 0.
    - Register all rsp_* outputs, set rsp_valid=1, go to RESP.
  - RESP: rsp_* held stable until rsp_valid && rsp_ready; then rsp_valid=0, go to IDLE.
- Latency: request accepted in cycle N; rsp_valid=1 in cycle N+2. Minimum issue interval is 3 cycles; req_ready=0 in ROLL and RESP.
- cfg writes are accepted in any state and take effect the next cycle. A request already accepted uses its latched values. A write to the same index in the cycle a request is accepted is not seen by that request.
- pp_refill in the same cycle as a ROLL decrement: refill wins, so the final PP is PP_INIT and rsp_pp_left reports PP_INIT.
- An out-of-range req_move (≥NUM_MOVES) is treated as index 0.
- rst_n asserted mid-operation: immediate return to reset values; any in-flight response is discarded.

Optional Feature:
- Macro MOVE_RESOLVER_CRIT_EN.
- Defined: on a hit, if lfsr[7:4]==4'b0000 in ROLL, rsp_crit=1 and rsp_dmg = min(2×dmg, all-ones) (saturating).
- Undefined: rsp_crit is tied 0 and damage is never doubled.

Decomposition:
- Package pbs_pkg:
  - default move table constants (dmg/acc per index);
  - state enum {IDLE, ROLL, RESP};
  - LFSR tap constant.
- Sub-module pbs_lfsr8 (free-running 8-bit LFSR with seed parameter), instantiated once.

Test Plan:
- After reset, request move 0 and hold rsp_ready=1 -> cycle N+2: rsp_valid=1, rsp_hit=1, rsp_dmg=3, rsp_pp_left=7.
- Request move 3 nine times -> requests 1-8 give rsp_pp_left 7..0; request 9 gives rsp_no_pp=1, rsp_hit=0, rsp_dmg=0, rsp_pp_left=0.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_* stable, req_ready=0 throughout; one response per request, none lost or duplicated.
- Write cfg idx1 dmg=9 acc=15, then request move 1 -> rsp_hit=1, rsp_dmg=9.
- Assert pp_refill in the ROLL cycle of move 2 when its PP=3 -> rsp_pp_left=8, and the following request reports 7.
- Drop rst_n during ROLL -> rsp_valid=0, req_ready=1; after release, PP=8 for all moves and the LFSR restarts from 8'hA5.
